// File: rtl/or_gate.sv
// Two-input OR with a registered copy, a rising-edge pulse and a saturating
// count of those pulses. y itself is purely combinational and ignores clk/rst.
module or_gate #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise_next;

  assign y         = a | b;
  // A rise is "y is 1 now but the registered copy is still 0".
  assign rise_next = y & ~y_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so y_rise and rise_cnt both see the old y_q in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= 1'b0;
      y_rise   <= 1'b0;
      rise_cnt <= '0;
    end else begin
      y_q    <= y;
      y_rise <= rise_next;
      // An unknown rise_next is not true, so X never advances the count.
      if (rise_next && (rise_cnt != CNT_MAX))
        rise_cnt <= rise_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: an event-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_or_gate;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       y, y_q, y_rise;
  logic [7:0] rise_cnt;
  logic       y2, y_q2, y_rise2;
  logic [1:0] rise_cnt2;

  int checks = 0;
  int errors = 0;
  int pulses2 = 0;

  or_gate #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .y(y), .y_q(y_q), .y_rise(y_rise), .rise_cnt(rise_cnt)
  );

  or_gate #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .y(y2), .y_q(y_q2), .y_rise(y_rise2), .rise_cnt(rise_cnt2)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember the last sampled OR value and count rising events.
  logic m_last;
  logic m_rise;
  int   m_events;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last   = 1'b0;
      m_rise   = 1'b0;
      m_events = 0;
    end else begin
      m_rise = (a | b) & ~m_last;
      m_last = a | b;
      if (m_rise === 1'b1) m_events++;
    end
  end

  always @(negedge clk) begin
    check("y_comb", {31'd0, y}, {31'd0, a | b});
    check("y_q", {31'd0, y_q}, {31'd0, m_last});
    check("y_rise", {31'd0, y_rise}, {31'd0, m_rise});
    check("rise_cnt8", {24'd0, rise_cnt}, (m_events > 255) ? 32'd255 : 32'(m_events));
    check("y_rise_w2", {31'd0, y_rise2}, {31'd0, m_rise});
    check("rise_cnt2", {30'd0, rise_cnt2}, (m_events > 3) ? 32'd3 : 32'(m_events));
    if (y_rise2 === 1'b1) pulses2++;
  end

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [1:0] vec;
  logic       bx = 1'bx;
  logic       exp_y;

  initial begin
    // Combinational truth table with no clock and no reset activity.
    for (int i = 0; i < 4; i++) begin
      vec = i[1:0];
      a = vec[1];
      b = vec[0];
      #10;
      check("truth_table", {31'd0, y}, {31'd0, (i != 0)});
    end

    // Async reset without any clock edge; y unaffected by reset.
    a = 1'b0; b = 1'b0;
    rst = 1'b1;
    #3;
    check("rst_y_q", {31'd0, y_q}, 32'd0);
    check("rst_y_rise", {31'd0, y_rise}, 32'd0);
    check("rst_cnt", {24'd0, rise_cnt}, 32'd0);
    clk_en = 1'b1;
    a = 1'b1;
    #1;
    check("y_during_rst", {31'd0, y}, 32'd1);
    cycle(2);
    check("rst_hold_y_q", {31'd0, y_q}, 32'd0);
    a = 1'b0;
    rst = 1'b0;

    // Three idle cycles, then a rises.
    cycle(3);
    check("idle_y_q", {31'd0, y_q}, 32'd0);
    a = 1'b1;
    cycle(1);
    check("first_rise_y_q", {31'd0, y_q}, 32'd1);
    check("first_rise_pulse", {31'd0, y_rise}, 32'd1);
    check("first_rise_cnt", {24'd0, rise_cnt}, 32'd1);
    cycle(1);
    check("sustained_no_pulse", {31'd0, y_rise}, 32'd0);
    check("sustained_cnt", {24'd0, rise_cnt}, 32'd1);
    a = 1'b0;
    cycle(2);
    check("fall_no_pulse_cnt", {24'd0, rise_cnt}, 32'd1);

    // Toggle b every two cycles with a low.
    pulses2 = 0;
    for (int i = 0; i < 4; i++) begin
      b = ~i[0];
      #1;
      check("y_follows_b", {31'd0, y}, {31'd0, b});
      cycle(2);
    end
    check("toggle_cnt", {24'd0, rise_cnt}, 32'd3);
    check("toggle_pulses", 32'(pulses2), 32'd2);

    // Saturation of the 2-bit counter after five events.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    pulses2 = 0;
    for (int i = 0; i < 5; i++) begin
      b = 1'b1;
      cycle(2);
      b = 1'b0;
      cycle(2);
    end
    check("sat_cnt2", {30'd0, rise_cnt2}, 32'd3);
    check("sat_cnt8", {24'd0, rise_cnt}, 32'd5);
    check("sat_pulses", 32'(pulses2), 32'd5);

    // Reset asserted mid-pulse with a=b=1 held.
    a = 1'b1; b = 1'b1;
    cycle(1);
    check("pre_rst_pulse", {31'd0, y_rise}, 32'd1);
    check("pre_rst_cnt", {24'd0, rise_cnt}, 32'd6);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_y_q", {31'd0, y_q}, 32'd0);
    check("mid_rst_pulse", {31'd0, y_rise}, 32'd0);
    check("mid_rst_cnt", {24'd0, rise_cnt}, 32'd0);
    check("mid_rst_y", {31'd0, y}, 32'd1);
    cycle(1);
    check("rst_held_cnt", {24'd0, rise_cnt}, 32'd0);
    rst = 1'b0;
    cycle(1);
    check("post_rst_y_q", {31'd0, y_q}, 32'd1);
    check("post_rst_pulse", {31'd0, y_rise}, 32'd1);
    check("post_rst_cnt", {24'd0, rise_cnt}, 32'd1);
    cycle(2);

    // Unknown operand: 1|X is 1, 0|X stays unknown and cannot count.
    b = bx;
    #1;
    check("one_or_x", {31'd0, y}, 32'd1);
    cycle(2);
    a = 1'b0;
    exp_y = 1'b0 | bx;
    #1;
    check("zero_or_x", {31'd0, y}, {31'd0, exp_y});
    cycle(2);
    check("x_cnt_unchanged", {24'd0, rise_cnt}, 32'd1);
    b = 1'b0;
    cycle(2);
    check("x_cnt_after", {24'd0, rise_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
